sort_cmd_driver: RTL and testbench
==================================

# sort_cmd_driver

Initiator for the 10-entry sort engine's command interface. Converts host push/pop/mode/sort commands into the engine's single-cycle in_valid1/in_valid2 strobes. Captures the 10-value descending result burst and checks its ordering. Sits between the host/test sequencer and the sort engine, which shares `clk` but has its own reset.

## Interface
- `CAP`, 10: engine capacity and result burst length.
- `TIMEOUT`, 32: maximum cycles from the sort strobe to the first `s_out_valid`.
- `GAP`, 3: idle cycles after the last result before `cmd_ready` reasserts. This covers the engine's OUT→IDLE→INPUT recovery.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: host command valid.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 0 = pop, 1 = push, 2 = sort, 3 = set mode.
- `cmd_data` in 5: push value.
- `cmd_mode` in 1: pop mode for op 3. 0 = pop tail (stack), 1 = pop head (queue).
- `cmd_err` out 1: one-cycle pulse when a command is rejected.
- `s_in_valid1`, `s_op[1:0]`, `s_in[4:0]` out: engine data/op strobe.
- `s_in_valid2`, `s_mode` out: engine mode strobe.
- `s_out_valid` in 1, `s_out` in 5: engine result stream.
- `res_valid` out 1, `res_data` out 5, `res_last` out 1: forwarded results. `res_last` is high on the CAP-th value.
- `order_err` out 1: sticky, set on any non-descending pair within a burst.
- `timeout_err` out 1: one-cycle pulse.
- `occupancy` out 4: driver's mirror of the engine fill level, 0..CAP.

## Operation
- States: IDLE, ISSUE, WAIT_OUT, RECV, GAP.
- IDLE: a handshake is `cmd_valid && cmd_ready`. On handshake:
  - Push with `occupancy == CAP` → `cmd_err`, stay in IDLE, no strobe.
  - Pop with `occupancy == 0` → `cmd_err`, stay in IDLE, no strobe.
  - Otherwise → ISSUE.
- ISSUE (exactly 1 cycle): drive the strobe, then update the mirror.
  - Push: `s_in_valid1 = 1`, `s_op = 1`, `s_in = cmd_data`; `occupancy += 1`; → IDLE.
  - Pop: `s_in_valid1 = 1`, `s_op = 0`; `occupancy -= 1`; → IDLE.
  - Mode: `s_in_valid2 = 1`, `s_mode = cmd_mode`; → IDLE.
  - Sort: `s_in_valid1 = 1`, `s_op = 2`; → WAIT_OUT.
- Strobe outputs are low in every other cycle; `s_in`, `s_op` and `s_mode` return to 0.
- WAIT_OUT: count cycles.
  - `s_out_valid` seen → RECV, capturing that value as beat 0.
  - Count reaches TIMEOUT → pulse `timeout_err`, clear `occupancy`, go to GAP.
- RECV: capture one value per cycle while `s_out_valid` is high.
  - Beat index runs 0..CAP-1; after beat CAP-1 → GAP.
  - `s_out_valid` dropping early → pulse `timeout_err`, go to GAP.
- Sort is legal with `occupancy == 0`; the engine returns CAP zeros. Zeros are padding and are forwarded unchanged.
- After a sort burst, `occupancy` resets to 0, because the engine clears its contents.
- Order check: beat k > beat k-1 (unsigned) sets `order_err`. Equal values are legal. Beat 0 is never an error.
- GAP: count GAP cycles → IDLE.
- `cmd_valid` outside IDLE is not accepted; the host holds it.

## Timing
- Reset values: all outputs 0, state IDLE, `occupancy` 0, `order_err` 0.
- Reset mid-burst or mid-ISSUE aborts immediately with no further strobes. The engine must be reset alongside.
- Strobe latency: the handshake in cycle t drives the strobe in cycle t+1, for exactly one cycle. The next `cmd_ready` is at t+2 at the earliest.
- `cmd_err` is asserted in cycle t+1 and `cmd_ready` stays high, so back-to-back commands are possible after a reject.
- Results: `res_*` are registered one cycle after the sampled `s_out_valid`/`s_out`.
- `order_err` updates in the same cycle as the offending `res_valid`.
- All outputs are registered; there is no combinational path from `s_out*` to `res_*`.

## Structure
- Package `sort_drv_pkg`:
  - op encodings: OP_POP = 0, OP_PUSH = 1, OP_SORT = 2, OP_MODE = 3;
  - `CAP_DEF` constant;
  - state enum;
  - 5-bit value typedef.
- One sub-module, `sort_result_checker`: beat counter, previous-value register, `order_err`/`res_last` generation.
- The top level holds the FSM, occupancy mirror, timeout and GAP counters.

## Test plan
- Push 7, 3, 9; sort; engine model returns 9,7,3,0×7 → ten `res_valid` beats in that order, `res_last` on the 10th, `order_err` = 0, `occupancy` 3→0.
- 10 pushes, then an 11th push → `cmd_err` pulse, no `s_in_valid1` for the 11th, `occupancy` stays 10.
- Pop at reset (empty) → `cmd_err`, no strobe. Mode 1 then pop after 2 pushes → `s_in_valid2`/`s_mode = 1` then `s_op = 0` on successive strobes, `occupancy` = 1.
- Model returns 5,8,... → `order_err` set at beat 1 and still 1 after the burst.
- Model never asserts `s_out_valid` → `timeout_err` at 32 cycles after the sort strobe, then `cmd_ready` after GAP.
- Assert `rst` during beat 4 of RECV → all outputs 0 next cycle, `cmd_ready` = 1, further `s_out_valid` ignored until a new sort.

Source files
------------

// File: rtl/sort_drv_pkg.sv
// rtl/sort_drv_pkg.sv - shared encodings and types for the sort engine command driver
package sort_drv_pkg;

    localparam logic [1:0] OP_POP  = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_SORT = 2'd2;
    localparam logic [1:0] OP_MODE = 2'd3;

    localparam int CAP_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_OUT,
        ST_RECV,
        ST_GAP
    } state_t;

    typedef logic [4:0] val_t;

endpackage

// File: rtl/sort_result_checker.sv
// rtl/sort_result_checker.sv - registers the result burst, flags the last beat and checks descending order
module sort_result_checker
    import sort_drv_pkg::*;
#(
    parameter int CAP = CAP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       active_i,
    input  logic       beat_valid_i,
    input  logic [4:0] beat_data_i,
    output logic       last_o,
    output logic       res_valid_o,
    output logic [4:0] res_data_o,
    output logic       res_last_o,
    output logic       order_err_o
);

    localparam int CW = $clog2(CAP + 1);

    logic [CW-1:0] cnt_q;
    val_t          prev_q;
    logic          res_valid_q;
    val_t          res_data_q;
    logic          res_last_q;
    logic          order_err_q;
    logic          accept;

    assign accept = active_i && beat_valid_i;
    assign last_o = accept && (cnt_q == CW'(CAP - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            prev_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            res_valid_q <= accept;
            res_data_q  <= accept ? beat_data_i : '0;
            res_last_q  <= last_o;
            // The beat counter only lives while a burst is expected.
            if (!active_i) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q  <= cnt_q + CW'(1);
                prev_q <= beat_data_i;
                if (cnt_q != '0 && beat_data_i > prev_q) begin
                    order_err_q <= 1'b1;
                end
            end
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_last_o  = res_last_q;
    assign order_err_o = order_err_q;

endmodule

// File: rtl/sort_cmd_driver.sv
// rtl/sort_cmd_driver.sv - turns host commands into sort engine strobes and collects the result burst
module sort_cmd_driver
    import sort_drv_pkg::*;
#(
    parameter int CAP     = CAP_DEF,
    parameter int TIMEOUT = 32,
    parameter int GAP     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [4:0] cmd_data,
    input  logic       cmd_mode,
    output logic       cmd_err,
    output logic       s_in_valid1,
    output logic [1:0] s_op,
    output logic [4:0] s_in,
    output logic       s_in_valid2,
    output logic       s_mode,
    input  logic       s_out_valid,
    input  logic [4:0] s_out,
    output logic       res_valid,
    output logic [4:0] res_data,
    output logic       res_last,
    output logic       order_err,
    output logic       timeout_err,
    output logic [3:0] occupancy
);

    localparam int CNT_W = $clog2(TIMEOUT + GAP + 1);

    state_t           state_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       occ_q;
    logic             cmd_ready_q;
    logic             cmd_err_q;
    logic             s_in_valid1_q;
    logic [1:0]       s_op_q;
    val_t             s_in_q;
    logic             s_in_valid2_q;
    logic             s_mode_q;
    logic             timeout_err_q;
    logic             active;
    logic             last_beat;

    assign active = (state_q == ST_WAIT_OUT) || (state_q == ST_RECV);

    sort_result_checker #(.CAP(CAP)) u_checker (
        .clk          (clk),
        .rst          (rst),
        .active_i     (active),
        .beat_valid_i (s_out_valid),
        .beat_data_i  (s_out),
        .last_o       (last_beat),
        .res_valid_o  (res_valid),
        .res_data_o   (res_data),
        .res_last_o   (res_last),
        .order_err_o  (order_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_POP;
            cnt_q         <= '0;
            occ_q         <= '0;
            cmd_ready_q   <= 1'b1;
            cmd_err_q     <= 1'b0;
            s_in_valid1_q <= 1'b0;
            s_op_q        <= '0;
            s_in_q        <= '0;
            s_in_valid2_q <= 1'b0;
            s_mode_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            cmd_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        if ((cmd_op == OP_PUSH && occ_q == 4'(CAP)) ||
                            (cmd_op == OP_POP && occ_q == 4'd0)) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            state_q     <= ST_ISSUE;
                            cmd_ready_q <= 1'b0;
                            op_q        <= cmd_op;
                            if (cmd_op == OP_MODE) begin
                                s_in_valid2_q <= 1'b1;
                                s_mode_q      <= cmd_mode;
                            end else begin
                                s_in_valid1_q <= 1'b1;
                                s_op_q        <= cmd_op;
                                s_in_q        <= (cmd_op == OP_PUSH) ? cmd_data : '0;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    s_in_valid1_q <= 1'b0;
                    s_in_valid2_q <= 1'b0;
                    s_op_q        <= '0;
                    s_in_q        <= '0;
                    s_mode_q      <= 1'b0;
                    // Counter starts at 1 so it measures cycles since the sort strobe.
                    if (op_q == OP_SORT) begin
                        state_q <= ST_WAIT_OUT;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                        if (op_q == OP_PUSH) begin
                            occ_q <= occ_q + 4'd1;
                        end else if (op_q == OP_POP) begin
                            occ_q <= occ_q - 4'd1;
                        end
                    end
                end
                ST_WAIT_OUT: begin
                    if (s_out_valid) begin
                        state_q <= ST_RECV;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        timeout_err_q <= 1'b1;
                        occ_q         <= '0;
                        cnt_q         <= '0;
                        state_q       <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RECV: begin
                    if (!s_out_valid) begin
                        timeout_err_q <= 1'b1;
                        occ_q         <= '0;
                        cnt_q         <= '0;
                        state_q       <= ST_GAP;
                    end else if (last_beat) begin
                        occ_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CNT_W'(GAP - 1)) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign cmd_err     = cmd_err_q;
    assign s_in_valid1 = s_in_valid1_q;
    assign s_op        = s_op_q;
    assign s_in        = s_in_q;
    assign s_in_valid2 = s_in_valid2_q;
    assign s_mode      = s_mode_q;
    assign timeout_err = timeout_err_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_sort_cmd_driver.sv
// tb/tb_sort_cmd_driver.sv - self-checking bench for sort_cmd_driver with a queue-based engine model
module tb_sort_cmd_driver;
    import sort_drv_pkg::*;

    localparam int CAP = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [4:0] cmd_data = '0;
    logic       cmd_mode = 1'b0;
    logic       cmd_err;
    logic       s_in_valid1;
    logic [1:0] s_op;
    logic [4:0] s_in;
    logic       s_in_valid2;
    logic       s_mode;
    logic       s_out_valid = 1'b0;
    logic [4:0] s_out = '0;
    logic       res_valid;
    logic [4:0] res_data;
    logic       res_last;
    logic       order_err;
    logic       timeout_err;
    logic [3:0] occupancy;

    always #5 clk = ~clk;

    sort_cmd_driver #(.CAP(CAP), .TIMEOUT(32), .GAP(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_mode(cmd_mode), .cmd_err(cmd_err),
        .s_in_valid1(s_in_valid1), .s_op(s_op), .s_in(s_in),
        .s_in_valid2(s_in_valid2), .s_mode(s_mode),
        .s_out_valid(s_out_valid), .s_out(s_out),
        .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
        .order_err(order_err), .timeout_err(timeout_err), .occupancy(occupancy)
    );

    typedef struct {
        logic [1:0] op;
        logic [4:0] data;
        logic       mode;
        int         exp_err;
        int         exp_occ;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    logic [4:0] eng[$];
    bit         model_mode = 1'b0;
    bit         exp_oerr = 1'b0;
    int         last_err;
    vec_t       tbl[7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int exp_steps, input string name);
        int n = 0;
        while (!cmd_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(name, n, exp_steps);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [4:0] data, input logic mode);
        bit rej;
        int n = 0;
        while (!cmd_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_cmd", int'(cmd_ready), 1);
        rej = (op == OP_PUSH && eng.size() == CAP) || (op == OP_POP && eng.size() == 0);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_mode = mode;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_mode = 1'b0;
        last_err = int'(cmd_err);
        check("cmd_err", int'(cmd_err), int'(rej));
        check("in_valid1", int'(s_in_valid1), int'(!rej && op != OP_MODE));
        check("in_valid2", int'(s_in_valid2), int'(!rej && op == OP_MODE));
        check("ready_t1", int'(cmd_ready), int'(rej));
        if (!rej) begin
            check("s_op", int'(s_op), (op == OP_MODE) ? 0 : int'(op));
            check("s_in", int'(s_in), (op == OP_PUSH) ? int'(data) : 0);
            check("s_mode", int'(s_mode), (op == OP_MODE) ? int'(mode) : 0);
            case (op)
                OP_PUSH: eng.push_back(data);
                OP_POP:  if (model_mode) void'(eng.pop_front()); else void'(eng.pop_back());
                OP_MODE: model_mode = mode;
                default: ;
            endcase
            if (op != OP_SORT) begin
                @(negedge clk);
                check("strobe_clear", int'({s_in_valid1, s_in_valid2, s_op, s_in, s_mode}), 0);
                check("ready_t2", int'(cmd_ready), 1);
            end
        end
        if (op != OP_SORT) check("occupancy", int'(occupancy), eng.size());
    endtask

    // Entered at the negedge of the sort strobe cycle; n < CAP models an early drop.
    task automatic run_burst(input logic [4:0] vals[$], input int lat, input int n);
        repeat (lat) @(negedge clk);
        s_out_valid = 1'b1;
        s_out = vals[0];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0 && vals[i] > vals[i-1]) exp_oerr = 1'b1;
            check("res_valid", int'(res_valid), 1);
            check("res_data", int'(res_data), int'(vals[i]));
            check("res_last", int'(res_last), int'(i == CAP - 1));
            check("order_err", int'(order_err), int'(exp_oerr));
            check("timeout_quiet", int'(timeout_err), 0);
            if (i + 1 < n) s_out = vals[i+1];
            else begin
                s_out_valid = 1'b0;
                s_out = '0;
            end
        end
        @(negedge clk);
        check("res_idle", int'(res_valid), 0);
        check("timeout_after_burst", int'(timeout_err), int'(n < CAP));
        wait_ready((n == CAP) ? 2 : 3, "gap_len");
        eng.delete();
        check("occ_after_sort", int'(occupancy), 0);
    endtask

    task automatic do_sort(input int lat);
        logic [4:0] b[$];
        logic [4:0] t;
        b = eng;
        while (b.size() < CAP) b.push_back(5'd0);
        for (int i = 0; i < CAP; i++)
            for (int j = i + 1; j < CAP; j++)
                if (b[j] > b[i]) begin
                    t = b[i]; b[i] = b[j]; b[j] = t;
                end
        send_cmd(OP_SORT, 5'd0, 1'b0);
        run_burst(b, lat, CAP);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0] burst[$];
        int n;
        int r;

        tbl[0] = '{OP_POP,  5'd0, 1'b0, 1, 0};
        tbl[1] = '{OP_MODE, 5'd0, 1'b1, 0, 0};
        tbl[2] = '{OP_PUSH, 5'd7, 1'b0, 0, 1};
        tbl[3] = '{OP_PUSH, 5'd3, 1'b0, 0, 2};
        tbl[4] = '{OP_POP,  5'd0, 1'b0, 0, 1};
        tbl[5] = '{OP_PUSH, 5'd7, 1'b0, 0, 2};
        tbl[6] = '{OP_PUSH, 5'd9, 1'b0, 0, 3};

        repeat (3) @(negedge clk);
        check("reset_ready", int'(cmd_ready), 1);
        check("reset_outputs", int'({cmd_err, s_in_valid1, s_op, s_in, s_in_valid2, s_mode,
              res_valid, res_data, res_last, order_err, timeout_err, occupancy}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send_cmd(tbl[i].op, tbl[i].data, tbl[i].mode);
            check("tbl_err", last_err, tbl[i].exp_err);
            check("tbl_occ", int'(occupancy), tbl[i].exp_occ);
        end
        burst = '{5'd9, 5'd7, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        send_cmd(OP_SORT, 5'd0, 1'b0);
        run_burst(burst, 4, CAP);

        for (int i = 0; i < 11; i++) begin
            send_cmd(OP_PUSH, 5'(i + 1), 1'b0);
            check("fill_err", last_err, int'(i == 10));
            check("fill_occ", int'(occupancy), (i < 10) ? i + 1 : 10);
        end
        do_sort(5);

        for (int k = 0; k < 120; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) send_cmd(OP_POP, 5'd0, 1'b0);
            else if (r == 6) send_cmd(OP_MODE, 5'd0, 1'($urandom_range(0, 1)));
            else if (r == 7) do_sort(int'($urandom_range(1, 30)));
            else send_cmd(OP_PUSH, 5'($urandom_range(0, 31)), 1'b0);
        end

        burst = '{5'd5, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
        send_cmd(OP_SORT, 5'd0, 1'b0);
        run_burst(burst, 3, CAP);
        check("order_err_sticky", int'(order_err), 1);

        send_cmd(OP_PUSH, 5'd4, 1'b0);
        send_cmd(OP_PUSH, 5'd2, 1'b0);
        send_cmd(OP_SORT, 5'd0, 1'b0);
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, 32);
        check("occ_timeout", int'(occupancy), 0);
        wait_ready(3, "timeout_gap");
        eng.delete();

        burst = '{5'd20, 5'd15, 5'd15, 5'd1};
        send_cmd(OP_SORT, 5'd0, 1'b0);
        run_burst(burst, 2, 4);

        send_cmd(OP_PUSH, 5'd6, 1'b0);
        send_cmd(OP_PUSH, 5'd1, 1'b0);
        send_cmd(OP_SORT, 5'd0, 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            s_out_valid = 1'b1;
            s_out = 5'(9 - i);
            if (i == 4) rst = 1'b1;
            @(negedge clk);
        end
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_outputs", int'({cmd_err, s_in_valid1, s_op, s_in, s_in_valid2, s_mode,
              res_valid, res_data, res_last, order_err, timeout_err, occupancy}), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ignored_after_rst", int'(res_valid), 0);
        end
        s_out_valid = 1'b0;
        s_out = '0;
        eng.delete();
        exp_oerr = 1'b0;
        model_mode = 1'b0;
        do_sort(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
